// File: rtl/stream_dequant_if.sv
// Coefficient beat stream in, dequantized raster row stream out, quant-table
// write port and sticky framing error, bundled for the dequantizer.
interface stream_dequant_if #(
   parameter int COEF_WIDTH = 16
);
   logic                    in_valid;
   logic                    in_ready;
   logic [4*COEF_WIDTH-1:0] in_data;
   logic                    in_last;
   logic                    out_valid;
   logic                    out_ready;
   logic [8*COEF_WIDTH-1:0] out_data;
   logic                    out_last;
   logic                    qt_we;
   logic [5:0]              qt_addr;
   logic [7:0]              qt_data;
   logic                    err;

   modport master (
      output in_valid, in_data, in_last, out_ready, qt_we, qt_addr, qt_data,
      input  in_ready, out_valid, out_data, out_last, err
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready, qt_we, qt_addr, qt_data,
      output in_ready, out_valid, out_data, out_last, err
   );
endinterface

// File: rtl/stream_dequant.sv
// Zigzag-to-raster dequantizer with a two-bank ping-pong block buffer; first row
// valid the cycle after beat 15, input stalls while both banks hold unread blocks.
module stream_dequant #(
   parameter int COEF_WIDTH = 16
) (
   input  logic            aclk,
   input  logic            areset,
   stream_dequant_if.slave bus
);
   localparam int CW = COEF_WIDTH;
   localparam int PW = COEF_WIDTH + 9;
   localparam logic signed [PW-1:0] SAT_MAX = {{10{1'b0}}, {(CW-1){1'b1}}};
   localparam logic signed [PW-1:0] SAT_MIN = {{10{1'b1}}, {(CW-1){1'b0}}};

   // Raster position of each zigzag index.
   localparam int ZZ [64] = '{
       0,  1,  8, 16,  9,  2,  3, 10,
      17, 24, 32, 25, 18, 11,  4,  5,
      12, 19, 26, 33, 40, 48, 41, 34,
      27, 20, 13,  6,  7, 14, 21, 28,
      35, 42, 49, 56, 57, 50, 43, 36,
      29, 22, 15, 23, 30, 37, 44, 51,
      58, 59, 52, 45, 38, 31, 39, 46,
      53, 60, 61, 54, 47, 55, 62, 63
   };

   logic [CW-1:0] r_mem [2][64];
   logic [7:0]    r_qt [64];
   logic [3:0]    r_beat;
   logic [2:0]    r_row;
   logic          r_wr_bank;
   logic          r_rd_bank;
   logic [1:0]    r_full;
   logic          r_err;

   logic                 w_in_rdy;
   logic                 w_out_vld;
   logic                 w_in_fire;
   logic                 w_out_fire;
   logic [5:0]           w_pos  [4];
   logic signed [CW-1:0] w_coef [4];
   logic signed [PW-1:0] w_prod [4];
   logic [CW-1:0]        w_val  [4];

   assign w_in_rdy   = !r_full[r_wr_bank];
   assign w_out_vld  = r_full[r_rd_bank];
   assign w_in_fire  = bus.in_valid && w_in_rdy;
   assign w_out_fire = w_out_vld && bus.out_ready;

   assign bus.in_ready  = w_in_rdy;
   assign bus.out_valid = w_out_vld;
   assign bus.out_last  = w_out_vld && (r_row == 3'd7);
   assign bus.err       = r_err;

   // Signed coefficient times unsigned step is exact in PW bits, then clamped.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         w_pos[i]  = 6'(ZZ[{r_beat, 2'(i)}]);
         w_coef[i] = bus.in_data[i*CW +: CW];
         w_prod[i] = PW'(w_coef[i]) * PW'($signed({1'b0, r_qt[w_pos[i]]}));
         if (w_prod[i] > SAT_MAX)
            w_val[i] = SAT_MAX[CW-1:0];
         else if (w_prod[i] < SAT_MIN)
            w_val[i] = SAT_MIN[CW-1:0];
         else
            w_val[i] = w_prod[i][CW-1:0];
      end
   end

   always_comb begin
      bus.out_data = '0;
      if (w_out_vld) begin
         for (int c = 0; c < 8; c++)
            bus.out_data[c*CW +: CW] = r_mem[r_rd_bank][{r_row, 3'(c)}];
      end
   end

   // Bank storage is deliberately left out of reset.
   always_ff @(posedge aclk) begin
      if (!areset && w_in_fire) begin
         for (int i = 0; i < 4; i++)
            r_mem[r_wr_bank][w_pos[i]] <= w_val[i];
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         r_beat    <= 4'd0;
         r_row     <= 3'd0;
         r_wr_bank <= 1'b0;
         r_rd_bank <= 1'b0;
         r_full    <= 2'b00;
         r_err     <= 1'b0;
         for (int a = 0; a < 64; a++)
            r_qt[a] <= 8'd1;
      end else begin
         if (bus.qt_we)
            r_qt[bus.qt_addr] <= bus.qt_data;

         // The beat counter alone frames blocks; in_last only feeds the error flag.
         if (w_in_fire) begin
            if (bus.in_last != (r_beat == 4'd15))
               r_err <= 1'b1;
            r_beat <= r_beat + 4'd1;
            if (r_beat == 4'd15) begin
               r_full[r_wr_bank] <= 1'b1;
               r_wr_bank         <= ~r_wr_bank;
            end
         end

         if (w_out_fire) begin
            r_row <= r_row + 3'd1;
            if (r_row == 3'd7) begin
               r_full[r_rd_bank] <= 1'b0;
               r_rd_bank         <= ~r_rd_bank;
            end
         end
      end
   end
endmodule

// File: tb/tb_stream_dequant.sv
// Randomized scoreboard bench for stream_dequant against a zigzag/saturation model.
`timescale 1ns/1ps
module tb_stream_dequant;
   localparam int CW = 16;

   logic aclk = 1'b0;
   logic areset = 1'b1;
   always #5 aclk = ~aclk;

   stream_dequant_if #(.COEF_WIDTH(CW)) bus ();
   stream_dequant #(.COEF_WIDTH(CW)) dut (.aclk(aclk), .areset(areset), .bus(bus));

   int checks = 0;
   int failures = 0;
   int zz [64];
   int m_qt [64];
   int m_blk [64];
   int m_beat = 0;
   bit m_err = 0;
   logic [8*CW-1:0] exp_rows [$];
   bit exp_last [$];
   int n_pops = 0;
   int rdy_mode = 0;
   bit rand_qt = 0;
   logic [8*CW-1:0] r7_seen = '0;
   int blk [64];
   int blk3 [3][64];

   function automatic void chk(string name, logic [8*CW-1:0] got, logic [8*CW-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         if (failures <= 40)
            $display("FAIL %s got=%h expected=%h", name, got, exp);
      end
   endfunction

   // Zigzag order by walking anti-diagonals, alternating direction.
   function automatic void build_zz();
      int k = 0;
      for (int s = 0; s < 15; s++) begin
         int lo = (s > 7) ? s - 7 : 0;
         int hi = (s < 8) ? s : 7;
         if (s % 2 == 0) begin
            for (int r = hi; r >= lo; r--) begin zz[k] = r*8 + (s - r); k++; end
         end else begin
            for (int r = lo; r <= hi; r++) begin zz[k] = r*8 + (s - r); k++; end
         end
      end
   endfunction

   task automatic model_accept(input logic [4*CW-1:0] dat, input bit last);
      int k, p, v;
      logic signed [CW-1:0] c;
      logic [8*CW-1:0] row;
      for (int i = 0; i < 4; i++) begin
         k = 4*m_beat + i;
         p = zz[k];
         c = dat[i*CW +: CW];
         v = int'(c) * m_qt[p];
         if (v > 32767) v = 32767;
         else if (v < -32768) v = -32768;
         m_blk[p] = v;
      end
      if (last != (m_beat == 15)) m_err = 1;
      if (m_beat == 15) begin
         for (int r = 0; r < 8; r++) begin
            for (int cc = 0; cc < 8; cc++) row[cc*CW +: CW] = CW'(m_blk[r*8 + cc]);
            exp_rows.push_back(row);
            exp_last.push_back(r == 7);
         end
      end
      m_beat = (m_beat + 1) % 16;
   endtask

   // One clock of stimulus; starts and ends 1ns after a rising edge.
   task automatic step(input bit vld, input logic [4*CW-1:0] dat, input bit last,
                       input bit qwe, input logic [5:0] qa, input logic [7:0] qd,
                       output bit fired);
      bus.in_valid = vld;
      bus.in_data  = dat;
      bus.in_last  = last;
      bus.qt_we    = qwe;
      bus.qt_addr  = qa;
      bus.qt_data  = qd;
      @(negedge aclk);
      fired = vld && bus.in_ready;
      if (fired) model_accept(dat, last);
      @(posedge aclk);
      #1;
      if (qwe) m_qt[qa] = int'(qd);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      bus.qt_we    = 1'b0;
      chk("err_flag", bus.err, m_err);
   endtask

   task automatic send_beat(input logic [4*CW-1:0] dat, input bit last, input bit gaps,
                            input bit fqwe, input logic [5:0] fqa, input logic [7:0] fqd);
      bit f = 0;
      int tries = 0;
      bit qwe;
      logic [5:0] qa;
      logic [7:0] qd;
      while (!f && tries < 300) begin
         qwe = 0; qa = '0; qd = '0;
         if (tries == 0 && fqwe) begin
            qwe = 1; qa = fqa; qd = fqd;
         end else if (rand_qt && $urandom_range(7) == 0) begin
            qwe = 1;
            qa  = 6'($urandom_range(63));
            qd  = ($urandom_range(3) == 0) ? 8'd0 : 8'($urandom_range(255));
         end
         if (gaps && $urandom_range(3) == 0) step(1'b0, dat, last, qwe, qa, qd, f);
         else step(1'b1, dat, last, qwe, qa, qd, f);
         tries++;
      end
      chk("beat_accepted", f, 1);
   endtask

   task automatic send_block(input int last_beat, input bit gaps, input bit fq,
                             input logic [5:0] fqa, input logic [7:0] fqd);
      for (int b = 0; b < 16; b++) begin
         logic [4*CW-1:0] d;
         for (int i = 0; i < 4; i++) d[i*CW +: CW] = CW'(blk[4*b + i]);
         send_beat(d, b == last_beat, gaps, fq && (b == 0), fqa, fqd);
      end
   endtask

   task automatic rand_blk();
      for (int k = 0; k < 64; k++)
         blk[k] = ($urandom_range(1) == 0) ? int'($urandom_range(200)) - 100
                                           : int'($urandom_range(65535)) - 32768;
   endtask

   task automatic do_reset();
      areset = 1'b1;
      @(posedge aclk); @(posedge aclk); #1;
      areset = 1'b0;
      exp_rows.delete();
      exp_last.delete();
      m_beat = 0;
      m_err  = 0;
      for (int a = 0; a < 64; a++) m_qt[a] = 1;
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((exp_rows.size() != 0 || bus.out_valid) && n < 3000) begin
         @(posedge aclk); #1; n++;
      end
      chk("drain_rows_left", exp_rows.size(), 0);
   endtask

   task automatic qt_write(input logic [5:0] a, input logic [7:0] d);
      bit f;
      step(1'b0, '0, 1'b0, 1'b1, a, d, f);
   endtask

   // out_ready driver
   initial begin
      bus.out_ready = 1'b0;
      forever begin
         @(posedge aclk);
         #2;
         case (rdy_mode)
            0:       bus.out_ready = 1'b0;
            1:       bus.out_ready = ($urandom_range(2) != 0);
            default: bus.out_ready = 1'b1;
         endcase
      end
   end

   // Scoreboard monitor: every valid cycle must show the queue head.
   initial begin
      forever begin
         @(negedge aclk);
         if (!areset) begin
            if (bus.out_valid) begin
               if (exp_rows.size() == 0) begin
                  chk("unexpected_row_valid", 1, 0);
               end else begin
                  chk("row_data", bus.out_data, exp_rows[0]);
                  chk("row_last", bus.out_last, exp_last[0]);
                  if (bus.out_ready) begin
                     if (exp_last[0]) r7_seen = exp_rows[0];
                     void'(exp_rows.pop_front());
                     void'(exp_last.pop_front());
                     n_pops++;
                  end
               end
            end else begin
               chk("idle_data_zero", bus.out_data, 0);
               chk("idle_last_zero", bus.out_last, 0);
            end
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog_timeout");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1);
   end

   initial begin
      logic [8*CW-1:0] rowc;
      int r0 [8] = '{0, 1, 5, 6, 14, 15, 27, 28};
      int r7 [8] = '{35, 36, 48, 49, 57, 58, 62, 63};
      int idx, acc, pre, base;
      bit f, got;
      logic [4*CW-1:0] d;

      build_zz();
      bus.in_valid = 0; bus.in_data = '0; bus.in_last = 0;
      bus.qt_we = 0; bus.qt_addr = '0; bus.qt_data = '0;

      do_reset();
      @(negedge aclk);
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_last", bus.out_last, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_err", bus.err, 0);
      @(posedge aclk); #1;

      // Identity table, coefficient = zigzag index
      rdy_mode = 0;
      for (int k = 0; k < 64; k++) blk[k] = k;
      send_block(15, 0, 0, '0, '0);
      @(negedge aclk);
      for (int c = 0; c < 8; c++) rowc[c*CW +: CW] = CW'(r0[c]);
      chk("ident_valid_latency", bus.out_valid, 1);
      chk("ident_row0", bus.out_data, rowc);
      chk("ident_row0_last", bus.out_last, 0);
      @(posedge aclk); #1;
      rdy_mode = 2;
      wait_drain();
      for (int c = 0; c < 8; c++) rowc[c*CW +: CW] = CW'(r7[c]);
      chk("ident_row7", r7_seen, rowc);

      // Saturation and zero step
      rdy_mode = 0;
      qt_write(6'd0, 8'd100);
      qt_write(6'd1, 8'd0);
      rand_blk(); blk[0] = 1000; blk[1] = 1234;
      send_block(15, 0, 0, '0, '0);
      @(negedge aclk);
      chk("sat_pos_dc", bus.out_data[CW-1:0], 16'h7fff);
      chk("zero_step_col1", bus.out_data[2*CW-1:CW], 0);
      @(posedge aclk); #1;
      rdy_mode = 2;
      wait_drain();
      rdy_mode = 0;
      rand_blk(); blk[0] = -1000;
      send_block(15, 0, 0, '0, '0);
      @(negedge aclk);
      chk("sat_neg_dc", bus.out_data[CW-1:0], 16'h8000);
      @(posedge aclk); #1;
      rdy_mode = 2;
      wait_drain();

      // Quant write in the same cycle as beat 0
      do_reset();
      rdy_mode = 0;
      rand_blk(); blk[0] = 300;
      send_block(15, 0, 1, 6'd0, 8'd2);
      @(negedge aclk);
      chk("qt_same_cycle_dc", bus.out_data[CW-1:0], 16'd300);
      @(posedge aclk); #1;
      rdy_mode = 2;
      wait_drain();
      rdy_mode = 0;
      rand_blk(); blk[0] = 300;
      send_block(15, 0, 0, '0, '0);
      @(negedge aclk);
      chk("qt_next_block_dc", bus.out_data[CW-1:0], 16'd600);
      @(posedge aclk); #1;
      rdy_mode = 2;
      wait_drain();

      // Framing error on beat 7, then held across good blocks
      rdy_mode = 1;
      rand_blk();
      send_block(7, 1, 0, '0, '0);
      for (int n = 0; n < 2; n++) begin rand_blk(); send_block(15, 1, 0, '0, '0); end
      wait_drain();
      chk("err_sticky", bus.err, 1);

      // Backpressure with both banks full
      do_reset();
      rdy_mode = 0;
      for (int b = 0; b < 3; b++)
         for (int k = 0; k < 64; k++) blk3[b][k] = int'($urandom_range(65535)) - 32768;
      idx = 0; acc = 0;
      for (int cyc = 0; cyc < 45; cyc++) begin
         for (int i = 0; i < 4; i++) d[i*CW +: CW] = CW'(blk3[idx/16][4*(idx%16) + i]);
         step(1'b1, d, (idx % 16) == 15, 1'b0, '0, '0, f);
         if (f) begin idx++; acc++; end
      end
      chk("bp_beats_accepted", acc, 32);
      @(negedge aclk);
      chk("bp_in_ready_low", bus.in_ready, 0);
      @(posedge aclk); #1;
      rdy_mode = 2;
      base = n_pops;
      got = 0;
      for (int cyc = 0; cyc < 40 && !got; cyc++) begin
         pre = n_pops;
         for (int i = 0; i < 4; i++) d[i*CW +: CW] = CW'(blk3[idx/16][4*(idx%16) + i]);
         step(1'b1, d, (idx % 16) == 15, 1'b0, '0, '0, f);
         if (f) begin
            got = 1;
            idx++;
            chk("bp_ready_after_8_rows", pre, base + 8);
         end
      end
      chk("bp_resume", got, 1);
      while (idx < 48) begin
         for (int i = 0; i < 4; i++) blk[i] = blk3[idx/16][4*(idx%16) + i];
         for (int i = 0; i < 4; i++) d[i*CW +: CW] = CW'(blk[i]);
         send_beat(d, (idx % 16) == 15, 0, 0, '0, '0);
         idx++;
      end
      wait_drain();

      // Reset with one block pending and a partial block in flight
      rdy_mode = 0;
      rand_blk();
      send_block(15, 0, 0, '0, '0);
      rand_blk();
      for (int b = 0; b < 5; b++) begin
         for (int i = 0; i < 4; i++) d[i*CW +: CW] = CW'(blk[4*b + i]);
         send_beat(d, 1'b0, 0, 0, '0, '0);
      end
      do_reset();
      @(negedge aclk);
      chk("midrst_out_valid", bus.out_valid, 0);
      chk("midrst_in_ready", bus.in_ready, 1);
      @(posedge aclk); #1;
      rdy_mode = 2;
      rand_blk();
      send_block(15, 0, 0, '0, '0);
      wait_drain();

      // Random traffic with random table updates
      rdy_mode = 1;
      rand_qt = 1;
      for (int n = 0; n < 12; n++) begin
         rand_blk();
         send_block(15, 1, 0, '0, '0);
      end
      rand_qt = 0;
      wait_drain();
      chk("final_err_clear", bus.err, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/stream_dequant.md
STREAM_DEQUANT -- requirements
Module: stream_dequant

Interface
REQ-001 Parameter: COEF_WIDTH, default 16, signed coefficient width on both input lanes and output lanes.
REQ-002 aclk  input  1  sole clock; all logic on rising edge.
REQ-003 areset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  input beat valid.
REQ-005 in_ready  output  1  input beat accepted when in_valid && in_ready.
REQ-006 in_data  input  4*COEF_WIDTH  four signed quantized coefficients; lane i = bits [16i+15:16i] = zigzag index 4*beat+i.
REQ-007 in_last  input  1  sender's end-of-block marker.
REQ-008 out_valid  output  1  output row valid.
REQ-009 out_ready  input  1  output row consumed when out_valid && out_ready.
REQ-010 out_data  output  8*COEF_WIDTH  one raster row, column c = bits [16c+15:16c], signed dequantized; feeds the IDCT stage row input.
REQ-011 out_last  output  1  high on row 7 of a block.
REQ-012 qt_we / qt_addr[5:0] / qt_data[7:0]  input  quant table write, raster-order address, unsigned step.
REQ-013 err  output  1  sticky framing error flag.

Function
REQ-014 Block = 16 input beats (64 coefficients, JPEG zigzag order) -> 8 output rows (raster order).
REQ-015 Each accepted coefficient: raster pos p = zigzag_to_raster(4*beat+i); value = coef * qt[p] (signed x unsigned, 24-bit exact), saturated to [-32768, 32767], written to the write bank at p in the same cycle.
REQ-016 Two-bank ping-pong buffer; each bank has a full flag; wr_bank and rd_bank are 1-bit pointers.
REQ-017 in_ready = !full[wr_bank].
REQ-018 Beat counter 0..15 is authoritative: on the accepted beat 15, set full[wr_bank], toggle wr_bank, clear counter.
REQ-019 in_last asserted on beat != 15, or deasserted on beat 15, sets err; block framing unchanged; err clears only on reset.
REQ-020 out_valid = full[rd_bank]; out_data = row row_cnt of rd_bank; out_last = (row_cnt == 7); out_data = 0 when out_valid low.
REQ-021 On output handshake, row_cnt increments; on row 7 handshake, clear full[rd_bank], toggle rd_bank, row_cnt = 0.
REQ-022 Latency: first row out_valid in the cycle after the beat-15 handshake.
REQ-023 Fill and drain of opposite banks in the same cycle are independent.
REQ-024 A bank freed in cycle N is not writable until N+1 (in_ready registered through full flag).
REQ-025 Both banks full: in_ready = 0 until a row-7 handshake.
REQ-026 qt write takes effect for beats accepted in later cycles; same-cycle beat uses the old value; qt[p] = 0 yields 0.
REQ-027 out_data/out_last stable while out_valid && !out_ready.

Reset
REQ-028 On areset: beat counter, row_cnt, wr_bank, rd_bank, full[1:0], err = 0; all qt entries = 1; in_ready = 1, out_valid = 0, out_last = 0, out_data = 0 the next cycle.
REQ-029 Reset mid-block discards partial/full banks; next accepted beat is beat 0 of a new block. Bank contents are not reset.

Verification
REQ-030 Identity table, coefficient at zigzag k = k -> row 0 = {0,1,5,6,14,15,27,28}, row 7 = {35,36,48,49,57,58,62,63}, out_last on row 7 only.
REQ-031 qt[0] = 100, DC = 1000 -> row 0 col 0 = 32767; DC = -1000 -> -32768; qt[1] = 0 -> col 1 = 0.
REQ-032 out_ready = 0, three blocks offered -> 32 beats accepted, in_ready = 0 at block 3 beat 0; after 8 row handshakes, in_ready = 1 next cycle.
REQ-033 in_last on beat 7 -> err = 1 from next cycle; block still emits 8 rows after beat 15; err held through later blocks.
REQ-034 areset after 5 beats of block 2 with block 1 pending output -> out_valid = 0, in_ready = 1; 16 new beats produce a correct block.
REQ-035 qt[0] = 2 written in the same cycle as beat 0 -> that block's DC is unscaled; next block's DC is doubled.
